// File: rtl/complete_add_seq.sv
// Registered adder for the 32-bit custom float word {exp[7:0] signed, mant[23:0] unsigned}.
// Optional mantissa carry output guarded by COMPLETE_ADD_CARRY_EN.

module csa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);
  logic [8:0] blk_c;

  function automatic logic [4:0] ripple4(input logic [3:0] x, input logic [3:0] y,
                                         input logic ci);
    logic [3:0] s;
    logic       c;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    return {c, s};
  endfunction

  assign blk_c[0] = cin;

  // Each nibble is precomputed for both carry-ins; the incoming block carry picks one.
  for (genvar g = 0; g < 8; g++) begin : g_blk
    logic [4:0] r0;
    logic [4:0] r1;
    assign r0             = ripple4(a[4*g +: 4], b[4*g +: 4], 1'b0);
    assign r1             = ripple4(a[4*g +: 4], b[4*g +: 4], 1'b1);
    assign sum[4*g +: 4]  = blk_c[g] ? r1[3:0] : r0[3:0];
    assign blk_c[g+1]     = blk_c[g] ? r1[4]   : r0[4];
  end

  assign cout = blk_c[8];
  assign ovf  = (a[31] == b[31]) && (sum[31] != a[31]);
endmodule

module negate_32 (
  input  logic        en,
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = en ? (~x + 32'd1) : x;
endmodule

module slt_structural (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        lt
);
  logic [31:0] diff;
  logic        cout_unused;
  logic        ovf;

  csa32 u_sub (
    .a    (a),
    .b    (~b),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout_unused),
    .ovf  (ovf)
  );

  assign lt = diff[31] ^ ovf;
endmodule

module complete_add_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  output logic [31:0] res
`ifdef COMPLETE_ADD_CARRY_EN
  ,
  output logic        carry_out
`endif
);
  logic signed [31:0] exp_a_p0;
  logic signed [31:0] exp_b_p0;
  logic               a_lt_b_p0;
  logic        [31:0] larger_p0;
  logic        [31:0] smaller_p0;
  logic signed [31:0] lexp_p0;
  logic signed [31:0] sexp_p0;
  logic        [31:0] sexp_neg_p0;
  logic        [31:0] shift_p0;
  logic               shift_cout_unused;
  logic               shift_ovf_unused;
  logic        [23:0] aligned_p0;
  logic        [31:0] mant_sum_p0;
  logic               mant_cout_unused;
  logic               mant_ovf_unused;
  logic        [6:0]  mant_hi_unused;
  logic               mant_carry_p0;
  logic        [23:0] mant_res_p0;
  logic        [31:0] res_p0;

  // The whole 32-bit difference is tested so that any bit above 23 forces a zero result.
  function automatic logic [23:0] align_mant(input logic [23:0] m, input logic [31:0] sh);
    if (sh >= 32'd24) return 24'd0;
    return m >> sh[4:0];
  endfunction

  // Stage p0: exponent compare, operand swap, alignment and mantissa add
  assign exp_a_p0 = {{24{op_a[31]}}, op_a[31:24]};
  assign exp_b_p0 = {{24{op_b[31]}}, op_b[31:24]};

  slt_structural u_slt (
    .a  (exp_a_p0),
    .b  (exp_b_p0),
    .lt (a_lt_b_p0)
  );

  assign larger_p0  = a_lt_b_p0 ? op_b : op_a;
  assign smaller_p0 = a_lt_b_p0 ? op_a : op_b;
  assign lexp_p0    = {{24{larger_p0[31]}},  larger_p0[31:24]};
  assign sexp_p0    = {{24{smaller_p0[31]}}, smaller_p0[31:24]};

  negate_32 u_neg (
    .en (1'b1),
    .x  (sexp_p0),
    .y  (sexp_neg_p0)
  );

  csa32 u_shift (
    .a    (lexp_p0),
    .b    (sexp_neg_p0),
    .cin  (1'b0),
    .sum  (shift_p0),
    .cout (shift_cout_unused),
    .ovf  (shift_ovf_unused)
  );

  assign aligned_p0 = align_mant(smaller_p0[23:0], shift_p0);

  csa32 u_mant (
    .a    ({8'd0, larger_p0[23:0]}),
    .b    ({8'd0, aligned_p0}),
    .cin  (1'b0),
    .sum  (mant_sum_p0),
    .cout (mant_cout_unused),
    .ovf  (mant_ovf_unused)
  );

  assign {mant_hi_unused, mant_carry_p0, mant_res_p0} = mant_sum_p0;
  assign res_p0 = {larger_p0[31:24], mant_res_p0};

  // Stage p1: output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      res       <= 32'd0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) res <= res_p0;
    end
  end

`ifdef COMPLETE_ADD_CARRY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      carry_out <= 1'b0;
    else if (in_valid) carry_out <= mant_carry_p0;
  end
`else
  logic mant_carry_unused;
  assign mant_carry_unused = mant_carry_p0;
`endif
endmodule

// File: tb/tb_complete_add_seq.sv
// Self-checking bench for complete_add_seq: directed table, corner sequences, random vs model.
`timescale 1ns/1ps

module tb_complete_add_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic [31:0] res;
`ifdef COMPLETE_ADD_CARRY_EN
  logic        carry_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  complete_add_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .res       (res)
`ifdef COMPLETE_ADD_CARRY_EN
    ,
    .carry_out (carry_out)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_carry;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Reference: signed exponent compare, plain integer shift and modulo-2^24 add.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, d;
    logic [31:0] l, s;
    longint      al, m;
    ea = int'($signed(a[31:24]));
    eb = int'($signed(b[31:24]));
    if (ea < eb) begin l = b; s = a; d = eb - ea; end
    else         begin l = a; s = b; d = ea - eb; end
    al = (d >= 24) ? 64'sd0 : (longint'(s[23:0]) >>> d);
    m  = longint'(l[23:0]) + al;
    return {m[24], l[31:24], m[23:0]};
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = v;
    op_a     = a;
    op_b     = b;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic check_carry(input string name, input logic want);
`ifdef COMPLETE_ADD_CARRY_EN
    check(name, {31'd0, carry_out}, {31'd0, want});
`else
    if (want === 1'bz) $display("unused");
`endif
  endtask

  initial begin
    logic [32:0] m;
    logic [31:0] exp_res;
    logic        exp_carry;
    logic        exp_vld;
    logic        v;
    logic [31:0] a, b;

    vecs[0] = '{32'h04000004, 32'h020000FF, 32'h04000043, 1'b0};
    vecs[1] = '{32'h01000010, 32'h01000020, 32'h01000030, 1'b0};
    vecs[2] = '{32'h02000100, 32'h05000008, 32'h05000028, 1'b0};
    vecs[3] = '{32'hFE000080, 32'h01000001, 32'h01000011, 1'b0};
    vecs[4] = '{32'h7F000001, 32'h80FFFFFF, 32'h7F000001, 1'b0};
    vecs[5] = '{32'h00FFFFFF, 32'h00000001, 32'h00000000, 1'b1};

    reset_n  = 1'b0;
    in_valid = 1'b0;
    op_a     = 32'd0;
    op_b     = 32'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Idle edge after reset release
    sample();
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_res", res, 32'd0);

    // Table vectors, back-to-back with in_valid held high
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b);
      sample();
      check($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check_carry($sformatf("vec%0d_carry", i), vecs[i].exp_carry);
    end

    // Hold on an idle edge
    drive(1'b0, 32'h12345678, 32'h9ABCDEF0);
    sample();
    check("hold_valid", {31'd0, out_valid}, 32'd0);
    check("hold_res", res, vecs[5].exp_res);
    check_carry("hold_carry", 1'b1);

    // Wrap then first vector on consecutive cycles
    drive(1'b1, vecs[5].a, vecs[5].b);
    sample();
    check("b2b_first", res, 32'h00000000);
    check_carry("b2b_first_carry", 1'b1);
    drive(1'b1, vecs[0].a, vecs[0].b);
    sample();
    check("b2b_second", res, 32'h04000043);
    check("b2b_second_valid", {31'd0, out_valid}, 32'd1);
    check_carry("b2b_second_carry", 1'b0);

    // Reset asserted away from any clock edge, while an operation is in flight
    drive(1'b1, vecs[2].a, vecs[2].b);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_res", res, 32'd0);
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check_carry("async_rst_carry", 1'b0);
    sample();
    check("rst_held_res", res, 32'd0);
    drive(1'b0, 32'd0, 32'd0);
    reset_n = 1'b1;
    sample();
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_res", res, 32'd0);

    // Randomised traffic against the model
    exp_res   = 32'd0;
    exp_carry = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) == 1) b[31:24] = a[31:24] + 8'($urandom_range(0, 30)) - 8'd15;
      drive(v, a, b);
      exp_vld = v;
      if (v) begin
        m         = model(a, b);
        exp_res   = m[31:0];
        exp_carry = m[32];
      end
      sample();
      check($sformatf("rnd%0d_valid", i), {31'd0, out_valid}, {31'd0, exp_vld});
      check($sformatf("rnd%0d_res", i), res, exp_res);
      check_carry($sformatf("rnd%0d_carry", i), exp_carry);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
